// File: rtl/shared_counters_pkg.sv
// Shared definitions for the shared-counter array and its clients.
//
// Contents:
//   - default array geometry (N_DEFAULT subcounters of G_DEFAULT bits)
//   - command encodings driven on command_out toward the array
//   - state type of the read collector FSM
package shared_counters_pkg;

  localparam int N_DEFAULT = 10;
  localparam int G_DEFAULT = 4;

  localparam logic [2:0] CMD_IDLE    = 3'b000;
  localparam logic [2:0] CMD_INC     = 3'b001;
  localparam logic [2:0] CMD_ALLOC   = 3'b010;
  localparam logic [2:0] CMD_DEALLOC = 3'b011;
  localparam logic [2:0] CMD_LOAD    = 3'b100;
  localparam logic [2:0] CMD_READ    = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    COLLECT,
    RESP
  } collector_state_e;

endpackage

// File: rtl/shared_counters_read_collector_rd_beat_packer.sv
// rd_beat_packer: accumulates serial G-bit beats into an N*G-bit word.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   clr        zero the accumulator and beat count (new read)
//   wr         store wdata at slot 'count' and advance the count
//   wdata      G-bit beat, least significant subcounter first
//   count      number of beats stored so far
//   data       accumulated value; slots not yet written read as 0
//   full       all N slots written
module rd_beat_packer
  import shared_counters_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int G = G_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   wr,
  input  logic [G-1:0]           wdata,
  output logic [$clog2(N+1)-1:0] count,
  output logic [N*G-1:0]         data,
  output logic                   full
);

  localparam int LW = $clog2(N+1);
  localparam logic [LW-1:0] N_FULL = LW'(N);

  logic [LW-1:0]  count_q, count_d;
  logic [N*G-1:0] data_q, data_d;

  // Clear wins over write; the caller never writes once full, so the
  // indexed slot always lies inside the accumulator.
  always_comb begin
    count_d = count_q;
    data_d  = data_q;
    if (clr) begin
      count_d = '0;
      data_d  = '0;
    end else if (wr) begin
      data_d[count_q*G +: G] = wdata;
      count_d                = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      data_q  <= '0;
    end else begin
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

  assign count = count_q;
  assign data  = data_q;
  assign full  = (count_q == N_FULL);

endmodule

// File: rtl/shared_counters_read_collector.sv
// shared_counters_read_collector: issues READ for one counter id to the
// shared-counter array, gathers the returned serial beats and offers the
// reassembled value on a valid/ready response port.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_ready/req_id   read request (base subcounter id)
//   command_out, id_out       command and id toward the array
//   rdata_in/rvalid_in/rlast_in  beats from the array, LS subcounter first
//   resp_valid/resp_ready     response handshake
//   resp_data, resp_len       assembled value (zero-extended), beat count
//   resp_err                  bad id, or no first beat before the timeout
//
// Build option: define READ_COLLECT_TIMEOUT_EN to abandon a read that sees
// no first beat within TIMEOUT cycles of ISSUE; without it ISSUE waits
// indefinitely.
module shared_counters_read_collector
  import shared_counters_pkg::*;
#(
  parameter int N       = N_DEFAULT,
  parameter int G       = G_DEFAULT,
  parameter int TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [$clog2(N)-1:0]   req_id,
  output logic [2:0]             command_out,
  output logic [$clog2(N)-1:0]   id_out,
  input  logic [G-1:0]           rdata_in,
  input  logic                   rvalid_in,
  input  logic                   rlast_in,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [N*G-1:0]         resp_data,
  output logic [$clog2(N+1)-1:0] resp_len,
  output logic                   resp_err
);

  localparam int IDW = $clog2(N);
  localparam int LW  = $clog2(N+1);
  localparam int TW  = $clog2(TIMEOUT+1);
  localparam logic [IDW:0]   N_ID     = (IDW+1)'(N);
  localparam logic [LW-1:0]  N_LAST   = LW'(N-1);
  localparam logic [TW-1:0]  TMO_MAX  = TW'(TIMEOUT);
`ifdef READ_COLLECT_TIMEOUT_EN
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT-1);
`endif

  collector_state_e state_q, state_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             err_q, err_d;
  logic [TW-1:0]    tmo_q, tmo_d;

  logic             pk_clr, pk_wr, pk_full;
  logic [LW-1:0]    pk_count;
  logic [N*G-1:0]   pk_data;

  logic             id_bad;
  assign id_bad = ({1'b0, req_id} >= N_ID);

  rd_beat_packer #(
    .N (N),
    .G (G)
  ) u_packer (
    .clk   (clk),
    .rst   (rst),
    .clr   (pk_clr),
    .wr    (pk_wr),
    .wdata (rdata_in),
    .count (pk_count),
    .data  (pk_data),
    .full  (pk_full)
  );

  // State and per-request registers; async reset drops command_out to idle
  // at once because command_out decodes straight from state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next state. A cycle without rvalid_in in COLLECT ends the read: the
  // array stops sending at the top subcounter without flagging last.
  // The ISSUE wait counter saturates; it only steers the FSM when the
  // timeout option is built in and is otherwise left without a load.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    pk_clr  = 1'b0;
    pk_wr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          pk_clr = 1'b1;
          id_d   = req_id;
          err_d  = 1'b0;
          tmo_d  = '0;
          if (id_bad) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (rvalid_in) begin
          pk_wr   = !pk_full;
          state_d = (rlast_in || N == 1) ? RESP : COLLECT;
        end else begin
          if (tmo_q != TMO_MAX) tmo_d = tmo_q + 1'b1;
`ifdef READ_COLLECT_TIMEOUT_EN
          if (tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = RESP;
          end
`endif
        end
      end
      COLLECT: begin
        if (!rvalid_in) begin
          state_d = RESP;
        end else begin
          pk_wr = !pk_full;
          if (rlast_in || pk_count == N_LAST) state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs; RESP always drives idle so the array rewinds its beat
  // pointer before the next READ.
  always_comb begin
    req_ready   = (state_q == IDLE);
    resp_valid  = (state_q == RESP);
    command_out = (state_q == ISSUE || state_q == COLLECT) ? CMD_READ : CMD_IDLE;
  end

  assign id_out    = id_q;
  assign resp_err  = err_q;
  assign resp_len  = pk_count;
  assign resp_data = pk_data;

endmodule
